// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit for the execute stage; owns the HI/LO registers.
//   MULT/MULTU  : multi-cycle, busy for MUL_LATENCY cycles, {hi,lo} <= product
//   DIV/DIVU    : restoring divider, busy for WIDTH+1 cycles (only with MDU_DIV_EN)
//   MTHI/MTLO   : single-cycle write of srcaE into hi/lo
// Build option: define MDU_DIV_EN to include the divider. Without it, DIV/DIVU are
// rejected like the reserved codes (unsupported pulse, no state change).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   startE, mdopE     issue strobe and op code (sampled only while idle)
//   srcaE, srcbE      rs / rt operands
//   busy              multi-cycle op in flight
//   done              one-cycle pulse after hi/lo written by a MULT/DIV
//   unsupported       one-cycle pulse for a rejected op code
//   hi, lo            HI/LO register contents
//
// state | meaning
// IDLE  | accepting ops; MTHI/MTLO complete here
// MUL   | multiply in flight, counting down the latency
// DIV   | one restoring quotient bit per cycle
// FIX   | sign correction and hi/lo write for divide
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       mdopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic             unsupported,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_LATENCY > WIDTH) ? MUL_LATENCY : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // opa/opb hold the multiply operands, or dividend-shifting-into-quotient / divisor
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic               msgn_q, msgn_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, unsup_q, unsup_d;
  logic [2*WIDTH-1:0] ma_ext, mb_ext, prod;

  assign ma_ext = msgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign mb_ext = msgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign prod   = ma_ext * mb_ext;

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, araw_q, araw_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dzero_q, dzero_d;
  logic             neg_a, neg_b, ge;
  logic [WIDTH:0]   shifted, diff;

  assign neg_a   = ~mdopE[0] & srcaE[WIDTH-1];
  assign neg_b   = ~mdopE[0] & srcbE[WIDTH-1];
  assign shifted = {rem_q, opa_q[WIDTH-1]};
  // shifted < 2*divisor, so the difference always fits in WIDTH+1 signed bits
  // and its top bit is a clean borrow
  assign diff    = shifted - {1'b0, opb_q};
  assign ge      = ~diff[WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    msgn_d  = msgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unsup_d = 1'b0;
`ifdef MDU_DIV_EN
    rem_d   = rem_q;
    araw_d  = araw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzero_d = dzero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (startE) begin
          case (mdopE)
            3'b000, 3'b001: begin
              state_d = S_MUL;
              opa_d   = srcaE;
              opb_d   = srcbE;
              msgn_d  = ~mdopE[0];
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end
            3'b100: hi_d = srcaE;
            3'b101: lo_d = srcaE;
`ifdef MDU_DIV_EN
            3'b010, 3'b011: begin
              state_d = S_DIV;
              opa_d   = neg_a ? -srcaE : srcaE;
              opb_d   = neg_b ? -srcbE : srcbE;
              qneg_d  = neg_a ^ neg_b;
              rneg_d  = neg_a;
              dzero_d = (srcbE == '0);
              araw_d  = srcaE;
              rem_d   = '0;
              cnt_d   = CNT_W'(WIDTH - 1);
            end
`endif
            default: unsup_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (dzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          // -2^(W-1)/-1 yields magnitude 2^(W-1); negation wraps to itself
          lo_d = qneg_q ? -opa_q : opa_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      msgn_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      unsup_q <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q   <= '0;
      araw_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      msgn_q  <= msgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      unsup_q <= unsup_d;
`ifdef MDU_DIV_EN
      rem_q   <= rem_d;
      araw_q  <= araw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dzero_q <= dzero_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign unsupported = unsup_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit (WIDTH=32, MUL_LATENCY=3). Divider cases run only
// when MDU_DIV_EN is defined; otherwise DIV/DIVU are expected to be rejected.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  logic [2:0]  mdopE;
  logic [31:0] srcaE, srcbE;
  logic        busy, done, unsupported;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .startE(startE), .mdopE(mdopE),
    .srcaE(srcaE), .srcbE(srcbE), .busy(busy), .done(done),
    .unsupported(unsupported), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op and count busy cycles; hi/lo must hold during the op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    startE = 1'b1; mdopE = op; srcaE = a; srcbE = b;
    tick();
    startE = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc == 1) begin
        chk("hold_hi", {32'd0, hi}, {32'd0, h0});
        chk("hold_lo", {32'd0, lo}, {32'd0, l0});
      end
      cyc++;
      tick();
    end
  endtask

  task automatic chk_res(input string tag, input int cyc, input int exp_cyc,
                         input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    reset = 1'b1; startE = 1'b0; mdopE = 3'b000; srcaE = '0; srcbE = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_unsup", {63'd0, unsupported}, 64'd0);
    chk("rst_hilo",  {hi, lo}, 64'd0);

    run_op(3'b000, 32'hFFFF_FFFF, 32'd2, n);
    chk_res("mult_m1x2", n, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("done_busy_excl", {63'd0, busy}, 64'd0);
    chk("done_unsup_excl", {63'd0, unsupported}, 64'd0);

    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, n);
    chk_res("multu_m1x2", n, 3, 32'h0000_0001, 32'hFFFF_FFFE);
    // MTLO issued in the done cycle
    startE = 1'b1; mdopE = 3'b101; srcaE = 32'h5;
    tick();
    startE = 1'b0;
    chk("mtlo_b2b_hilo", {hi, lo}, {32'h1, 32'h5});
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    chk("mtlo_done", {63'd0, done}, 64'd0);

    startE = 1'b1; mdopE = 3'b100; srcaE = 32'h0000_ABCD;
    tick();
    startE = 1'b0;
    chk("mthi_hilo", {hi, lo}, {32'h0000_ABCD, 32'h5});

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, n);
    chk_res("mult_m3x5", n, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(3'b000, 32'h8000_0000, 32'd2, n);
    chk_res("mult_min_x2", n, 3, 32'hFFFF_FFFF, 32'h0);
    run_op(3'b001, 32'h8000_0000, 32'd2, n);
    chk_res("multu_min_x2", n, 3, 32'h1, 32'h0);

    // reserved code 110
    startE = 1'b1; mdopE = 3'b110; srcaE = 32'h1234;
    tick();
    startE = 1'b0;
    chk("rsv_unsup", {63'd0, unsupported}, 64'd1);
    chk("rsv_busy", {63'd0, busy}, 64'd0);
    chk("rsv_done", {63'd0, done}, 64'd0);
    chk("rsv_hilo", {hi, lo}, {32'h1, 32'h0});
    tick();
    chk("rsv_unsup_pulse", {63'd0, unsupported}, 64'd0);

`ifdef MDU_DIV_EN
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, n);
    chk_res("div_m7_2", n, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, n);
    chk_res("div_7_m2", n, 33, 32'h1, 32'hFFFF_FFFD);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk_res("div_ovf", n, 33, 32'h0, 32'h8000_0000);
    run_op(3'b011, 32'd100, 32'd0, n);
    chk_res("divu_by0", n, 33, 32'h64, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd0, n);
    chk_res("div_m7_by0", n, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd16, n);
    chk_res("divu_big", n, 33, 32'hF, 32'h0FFF_FFFF);

    // MULT issued while a DIV is busy must be ignored
    startE = 1'b1; mdopE = 3'b011; srcaE = 32'd100; srcbE = 32'd7;
    tick();
    startE = 1'b0;
    tick(); tick();
    startE = 1'b1; mdopE = 3'b000; srcaE = 32'hFFFF_FFFF; srcbE = 32'd2;
    tick();
    startE = 1'b0;
    n = 3;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk_res("divu_ignore_mult", n, 33, 32'd2, 32'd14);

    // reset at cycle 10 of a DIV
    startE = 1'b1; mdopE = 3'b010; srcaE = 32'd1000; srcbE = 32'd3;
    tick();
    startE = 1'b0;
    repeat (9) tick();
    chk("div_mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("div_rst_busy", {63'd0, busy}, 64'd0);
    chk("div_rst_hilo", {hi, lo}, 64'd0);
    chk("div_rst_done", {63'd0, done}, 64'd0);
    tick();
    chk("div_rst_nodone", {63'd0, done}, 64'd0);
`else
    startE = 1'b1; mdopE = 3'b100; srcaE = 32'h0000_0077;
    tick();
    startE = 1'b1; mdopE = 3'b011; srcaE = 32'd100; srcbE = 32'd3;
    tick();
    startE = 1'b0;
    chk("nodiv_busy", {63'd0, busy}, 64'd0);
    chk("nodiv_unsup", {63'd0, unsupported}, 64'd1);
    chk("nodiv_hilo", {hi, lo}, {32'h77, 32'h0});
    tick();
    chk("nodiv_unsup_pulse", {63'd0, unsupported}, 64'd0);
    chk("nodiv_busy2", {63'd0, busy}, 64'd0);
    chk("nodiv_done", {63'd0, done}, 64'd0);
`endif

    // reset in the middle of a MULT
    startE = 1'b1; mdopE = 3'b001; srcaE = 32'd9; srcbE = 32'd9;
    tick();
    startE = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mul_rst_busy", {63'd0, busy}, 64'd0);
    chk("mul_rst_hilo", {hi, lo}, 64'd0);
    tick();
    chk("mul_rst_nodone", {63'd0, done}, 64'd0);
    chk("mul_rst_hilo2", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
